// File: rtl/control_sequencer.sv
// control_sequencer: Moore control FSM sequencing fetch/execute strobes for the CPU datapath
module control_sequencer #(
  parameter int MEM_WAIT = 1
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] ir,
  input  logic        con_ff,
  input  logic        stop,
  output logic        run,
  output logic [4:0]  alu_op,
  output logic        Gra, Grb, Grc,
  output logic        Rin, Rout, BAout, Cout,
  output logic        PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin,
  output logic        ZHighIn, ZLowIn, ZHighout, ZLowout, HIin, LOin, HIout, LOout,
  output logic        Read, RAM_write_en, InPortout, enableOutputPort, enableCon
);
  typedef enum logic [3:0] {RST_ST, HALT, F0, FW, F2, F3, E0, E1, E2, E3, E4, E5} state_t;
  state_t state, nxt;
  logic [1:0] cnt;
  logic [4:0] op;
  logic ir_unused;
  logic rt, imm, ldi, ld, st, md, nn, br, jr, inp, outp, mfhi, mflo, hlt, exec;
  logic f0, fw, f2, f3, e0, e1, e2, e3, e4, e5, last, wait_st, waited;
  state_t to_f0;
  assign op = ir[31:27];
  assign ir_unused = ^ir[26:0];
  assign rt   = op >= 5'd3 && op <= 5'd10;
  assign imm  = op >= 5'd11 && op <= 5'd13;
  assign ldi  = op == 5'd1;
  assign ld   = op == 5'd0;
  assign st   = op == 5'd2;
  assign md   = op == 5'd14 || op == 5'd15;
  assign nn   = op == 5'd16 || op == 5'd17;
  assign br   = op == 5'd18;
  assign jr   = op == 5'd19;
  assign inp  = op == 5'd21;
  assign outp = op == 5'd22;
  assign mfhi = op == 5'd23;
  assign mflo = op == 5'd24;
  assign hlt  = op == 5'd26;
  assign exec = rt | imm | ldi | ld | st | md | nn | br | jr | inp | outp | mfhi | mflo;
  assign f0 = state == F0;
  assign fw = state == FW;
  assign f2 = state == F2;
  assign f3 = state == F3;
  assign e0 = state == E0;
  assign e1 = state == E1;
  assign e2 = state == E2;
  assign e3 = state == E3;
  assign e4 = state == E4;
  assign e5 = state == E5;
  assign last = (e0 & (jr | inp | outp | mfhi | mflo)) | (e1 & nn) | (e2 & (rt | imm | ldi)) |
                (e3 & (md | br)) | (e4 & st) | (e5 & ld);
  assign wait_st = fw | (e3 & ld);
  assign waited = cnt == 2'(MEM_WAIT - 1);
  assign to_f0 = stop ? HALT : F0;
  // State register plus the memory wait counter shared by fetch and ld execute
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= RST_ST;
      cnt   <= 2'd0;
    end else begin
      state <= nxt;
      cnt   <= (wait_st && !waited) ? cnt + 2'd1 : 2'd0;
    end
  end
  // Next-state selection and Moore strobe decode from state and opcode
  always_comb begin
    nxt = state;
    case (state)
      RST_ST:  nxt = to_f0;
      HALT:    nxt = HALT;
      F0:      nxt = FW;
      FW:      nxt = waited ? F2 : FW;
      F2:      nxt = F3;
      F3:      nxt = hlt ? HALT : exec ? E0 : to_f0;
      default: nxt = (e3 && ld && !waited) ? E3 : (last || e5) ? to_f0 : state_t'(state + 4'd1);
    endcase
    run              = state != RST_ST && state != HALT;
    Gra              = (e0 & (md | br | jr | inp | outp | mfhi | mflo)) | (e1 & nn) |
                       (e2 & (rt | imm | ldi)) | (e3 & st) | (e5 & ld);
    Grb              = (e0 & (rt | imm | ldi | ld | st | nn)) | (e1 & md);
    Grc              = e1 & rt;
    Rin              = (e0 & (inp | mfhi | mflo)) | (e1 & nn) | (e2 & (rt | imm | ldi)) | (e5 & ld);
    Rout             = (e0 & (rt | imm | md | nn | br | jr | outp)) | (e1 & (rt | md)) | (e3 & st);
    BAout            = e0 & (ldi | ld | st);
    Cout             = (e1 & (imm | ldi | ld | st)) | (e2 & br);
    PCout            = f0 | (e1 & br);
    PCin             = (e0 & jr) | (e3 & br & con_ff);
    IncPC            = f0;
    MARin            = f0 | (e2 & (ld | st));
    MDRin            = f2 | (e4 & ld) | (e3 & st);
    MDRout           = f3 | (e5 & ld);
    IRin             = f3;
    Yin              = (e0 & (rt | imm | ldi | ld | st | md)) | (e1 & br);
    ZHighIn          = e1 & md;
    ZLowIn           = (e0 & nn) | (e1 & (rt | imm | ldi | ld | st | md)) | (e2 & br);
    ZHighout         = e3 & md;
    ZLowout          = (e1 & nn) | (e2 & (rt | imm | ldi | ld | st | md)) | (e3 & br);
    HIin             = e3 & md;
    LOin             = e2 & md;
    HIout            = e0 & mfhi;
    LOout            = e0 & mflo;
    Read             = fw | f2 | ((e3 | e4) & ld);
    RAM_write_en     = e4 & st;
    InPortout        = e0 & inp;
    enableOutputPort = e0 & outp;
    enableCon        = e0 & br;
    alu_op           = ((e1 & (rt | imm)) | ((e0 | e1) & (md | nn))) ? op :
                       ((e1 & (ld | ldi | st)) | (e2 & br)) ? 5'd3 : 5'd0;
  end
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed-vector check of control_sequencer strobes per cycle
module tb_control_sequencer;
  localparam logic [28:0] RUN = 29'd1 << 28, GRA = 29'd1 << 27, GRB = 29'd1 << 26, GRC = 29'd1 << 25;
  localparam logic [28:0] RIN = 29'd1 << 24, ROUT = 29'd1 << 23, BAOUT = 29'd1 << 22, COUT = 29'd1 << 21;
  localparam logic [28:0] PCOUT = 29'd1 << 20, PCIN = 29'd1 << 19, INCPC = 29'd1 << 18, MARIN = 29'd1 << 17;
  localparam logic [28:0] MDRIN = 29'd1 << 16, MDROUT = 29'd1 << 15, IRIN = 29'd1 << 14, YIN = 29'd1 << 13;
  localparam logic [28:0] ZLI = 29'd1 << 11, ZLO = 29'd1 << 9, READ = 29'd1 << 4, RAMW = 29'd1 << 3;
  localparam logic [28:0] ENCON = 29'd1 << 0;
  localparam logic [31:0] ADD = 32'h1989_0000, LD = 32'h0080_0005, ST = 32'h1080_0005;
  localparam logic [31:0] BR = 32'h9000_0004, UNDEF = 32'hF800_0000, HLT = 32'hD000_0000;
  logic clk = 0, clr = 0, clr2 = 0, con_ff = 0, stop = 0;
  logic [31:0] ir = ADD;
  wire [28:0] s1, s2;
  wire [4:0] a1, a2;
  int n_tests = 0, n_fail = 0;
  always #5 clk = ~clk;
  control_sequencer #(.MEM_WAIT(1)) dut (
    .clk(clk), .clr(clr), .ir(ir), .con_ff(con_ff), .stop(stop), .run(s1[28]), .alu_op(a1),
    .Gra(s1[27]), .Grb(s1[26]), .Grc(s1[25]), .Rin(s1[24]), .Rout(s1[23]), .BAout(s1[22]), .Cout(s1[21]),
    .PCout(s1[20]), .PCin(s1[19]), .IncPC(s1[18]), .MARin(s1[17]), .MDRin(s1[16]), .MDRout(s1[15]),
    .IRin(s1[14]), .Yin(s1[13]), .ZHighIn(s1[12]), .ZLowIn(s1[11]), .ZHighout(s1[10]), .ZLowout(s1[9]),
    .HIin(s1[8]), .LOin(s1[7]), .HIout(s1[6]), .LOout(s1[5]), .Read(s1[4]), .RAM_write_en(s1[3]),
    .InPortout(s1[2]), .enableOutputPort(s1[1]), .enableCon(s1[0]));
  control_sequencer #(.MEM_WAIT(3)) dut3 (
    .clk(clk), .clr(clr2), .ir(ir), .con_ff(con_ff), .stop(stop), .run(s2[28]), .alu_op(a2),
    .Gra(s2[27]), .Grb(s2[26]), .Grc(s2[25]), .Rin(s2[24]), .Rout(s2[23]), .BAout(s2[22]), .Cout(s2[21]),
    .PCout(s2[20]), .PCin(s2[19]), .IncPC(s2[18]), .MARin(s2[17]), .MDRin(s2[16]), .MDRout(s2[15]),
    .IRin(s2[14]), .Yin(s2[13]), .ZHighIn(s2[12]), .ZLowIn(s2[11]), .ZHighout(s2[10]), .ZLowout(s2[9]),
    .HIin(s2[8]), .LOin(s2[7]), .HIout(s2[6]), .LOout(s2[5]), .Read(s2[4]), .RAM_write_en(s2[3]),
    .InPortout(s2[2]), .enableOutputPort(s2[1]), .enableCon(s2[0]));
  function automatic logic [33:0] e(input logic [4:0] alu, input logic [28:0] m);
    return {alu, RUN | m};
  endfunction
  task automatic chk(input string tag, input logic [33:0] got, input logic [33:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got alu=%b strobes=%b, expected alu=%b strobes=%b",
               tag, got[33:29], got[28:0], exp[33:29], exp[28:0]);
    end
  endtask
  task automatic cyc(input string tag, input logic [33:0] exp);
    @(posedge clk);
    #1 chk(tag, {a1, s1}, exp);
  endtask
  task automatic cyc2(input string tag, input logic [33:0] exp);
    @(posedge clk);
    #1 chk(tag, {a2, s2}, exp);
  endtask
  task automatic fetch_rest(input string tag);
    cyc({tag, "_fw"}, e(0, READ));
    cyc({tag, "_f2"}, e(0, READ | MDRIN));
    cyc({tag, "_f3"}, e(0, MDROUT | IRIN));
  endtask
  task automatic reset_to_f0(input string tag);
    clr = 0;
    #1 chk({tag, "_clr"}, {a1, s1}, 34'd0);
    @(negedge clk) clr = 1;
    cyc({tag, "_f0"}, e(0, PCOUT | MARIN | INCPC));
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1 chk("rst_hold", {a1, s1}, 34'd0);
    @(negedge clk) clr = 1;
    cyc("rst_f0", e(0, PCOUT | MARIN | INCPC));
    fetch_rest("pre");
    cyc("pre_e0", e(0, GRB | ROUT | YIN));
    cyc("pre_e1", e(5'd3, GRC | ROUT | ZLI));
    reset_to_f0("abort");
    fetch_rest("add");
    cyc("add_e0", e(0, GRB | ROUT | YIN));
    cyc("add_e1", e(5'd3, GRC | ROUT | ZLI));
    cyc("add_e2", e(0, ZLO | GRA | RIN));
    cyc("add_f0", e(0, PCOUT | MARIN | INCPC));
    ir = LD;
    fetch_rest("ld");
    cyc("ld_e0", e(0, GRB | BAOUT | YIN));
    cyc("ld_e1", e(5'd3, COUT | ZLI));
    cyc("ld_e2", e(0, ZLO | MARIN));
    cyc("ld_e3", e(0, READ));
    cyc("ld_e4", e(0, READ | MDRIN));
    cyc("ld_e5", e(0, MDROUT | GRA | RIN));
    cyc("ld_f0", e(0, PCOUT | MARIN | INCPC));
    ir = ST;
    fetch_rest("st");
    cyc("st_e0", e(0, GRB | BAOUT | YIN));
    cyc("st_e1", e(5'd3, COUT | ZLI));
    cyc("st_e2", e(0, ZLO | MARIN));
    cyc("st_e3", e(0, GRA | ROUT | MDRIN));
    cyc("st_e4", e(0, RAMW));
    cyc("st_f0", e(0, PCOUT | MARIN | INCPC));
    ir = BR;
    for (int c = 0; c < 2; c++) begin
      con_ff = c[0];
      fetch_rest("br");
      cyc("br_e0", e(0, GRA | ROUT | ENCON));
      cyc("br_e1", e(0, PCOUT | YIN));
      cyc("br_e2", e(5'd3, COUT | ZLI));
      cyc("br_e3", e(0, c[0] ? (ZLO | PCIN) : ZLO));
      cyc("br_f0", e(0, PCOUT | MARIN | INCPC));
    end
    con_ff = 0;
    ir = UNDEF;
    fetch_rest("undef");
    cyc("undef_f0", e(0, PCOUT | MARIN | INCPC));
    ir = HLT;
    fetch_rest("halt");
    for (int i = 0; i < 20; i++) cyc("halt_idle", 34'd0);
    ir = ADD;
    reset_to_f0("rehalt");
    fetch_rest("stop");
    cyc("stop_e0", e(0, GRB | ROUT | YIN));
    stop = 1;
    cyc("stop_e1", e(5'd3, GRC | ROUT | ZLI));
    cyc("stop_e2", e(0, ZLO | GRA | RIN));
    cyc("stop_halt", 34'd0);
    stop = 0;
    cyc("stop_stay", 34'd0);
    @(negedge clk) clr2 = 1;
    cyc2("w3_f0", e(0, PCOUT | MARIN | INCPC));
    for (int i = 0; i < 3; i++) cyc2("w3_fw", e(0, READ));
    cyc2("w3_f2", e(0, READ | MDRIN));
    cyc2("w3_f3", e(0, MDROUT | IRIN));
    cyc2("w3_e0", e(0, GRB | ROUT | YIN));
    cyc2("w3_e1", e(5'd3, GRC | ROUT | ZLI));
    cyc2("w3_e2", e(0, ZLO | GRA | RIN));
    cyc2("w3_next_f0", e(0, PCOUT | MARIN | INCPC));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Moore-style control FSM directly upstream of the CPU datapath.
- Decodes the IR opcode field ir[31:27].
- Drives every bus-select, register-enable and memory strobe the datapath consumes, one control step per clock.
- Sequences fetch, then opcode-specific execute steps, then returns to fetch. Supports halt and stop.

Parameters:
MEM_WAIT, 1, Read-only wait cycles (1..3) between MARin and the MDRin capture, covering synchronous RAM latency.

Ports:
clk  input  1  clock, rising edge
clr  input  1  reset, asynchronous, active-low
ir  input  32  IR contents; opcode ir[31:27]
con_ff  input  1  branch condition flip-flop from datapath
stop  input  1  level request to halt after current instruction
run  output  1  1 while executing; 0 in RST_ST and HALT
alu_op  output  5  ALU operation code
Gra, Grb, Grc  output  1 each  register-field selects
Rin, Rout, BAout, Cout  output  1 each  register file / immediate bus controls
PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin  output  1 each  datapath register controls
ZHighIn, ZLowIn, ZHighout, ZLowout, HIin, LOin, HIout, LOout  output  1 each  Z/HI/LO controls
Read, RAM_write_en, InPortout, enableOutputPort, enableCon  output  1 each  memory/IO/branch strobes

Behaviour:
- clr=0: state forced to RST_ST immediately (async). All outputs are 0 and alu_op=00000 while clr is low.
- RST_ST lasts one cycle, then goes to F0.
- Outputs are a pure function of the state register and ir[31:27]. The only exception is E3 of br, which gates PCin with con_ff.
- Unlisted strobes are 0 in every state.
- Fetch sequence:
  - F0: PCout, MARin, IncPC.
  - FW: Read, held MEM_WAIT cycles via an internal wait counter.
  - F2: Read, MDRin.
  - F3: MDRout, IRin.
  - Fetch takes 3+MEM_WAIT cycles.
- Opcodes and execute steps (E0..E5). The last listed step returns to F0:
  - R-type: add 00011, sub 00100, and 00101, or 00110, shr 00111, shl 01000, ror 01001, rol 01010.
    - E0 Grb,Rout,Yin; E1 Grc,Rout,ZLowIn; E2 ZLowout,Gra,Rin.
  - Immediate: addi 01011, andi 01100, ori 01101.
    - E0 Grb,Rout,Yin; E1 Cout,ZLowIn; E2 ZLowout,Gra,Rin.
  - ldi 00001: E0 Grb,BAout,Yin; E1 Cout,ZLowIn; E2 ZLowout,Gra,Rin.
  - ld 00000:
    - E0 Grb,BAout,Yin; E1 Cout,ZLowIn; E2 ZLowout,MARin.
    - E3 Read (MEM_WAIT cycles); E4 Read,MDRin; E5 MDRout,Gra,Rin.
  - st 00010:
    - E0–E2 as ld.
    - E3 Gra,Rout,MDRin (Read=0); E4 RAM_write_en.
  - mul 01110, div 01111: E0 Gra,Rout,Yin; E1 Grb,Rout,ZHighIn,ZLowIn; E2 ZLowout,LOin; E3 ZHighout,HIin.
  - neg 10000, not 10001: E0 Grb,Rout,ZLowIn; E1 ZLowout,Gra,Rin.
  - br 10010: E0 Gra,Rout,enableCon; E1 PCout,Yin; E2 Cout,ZLowIn; E3 ZLowout, plus PCin iff con_ff=1.
  - jr 10011: E0 Gra,Rout,PCin.
  - in 10101: E0 InPortout,Gra,Rin.
  - out 10110: E0 Gra,Rout,enableOutputPort.
  - mfhi 10111: E0 HIout,Gra,Rin.
  - mflo 11000: E0 LOout,Gra,Rin.
  - nop 11001 and every undefined opcode: no execute steps; F3 goes straight to F0.
  - halt 11010: F3 goes to HALT.
- alu_op:
  - Equals ir[31:27] in E1 of R-type/immediate and in E0/E1 of mul/div/neg/not.
  - Equals 00011 (add) in E1 of ld/ldi/st and E2 of br.
  - Is 00000 elsewhere.
- stop: sampled on the transition into F0. If stop=1, go to HALT instead; the current instruction always completes.
- HALT is absorbing: all strobes 0, run=0. Exit only via clr.
- clr asserted mid-instruction aborts it; no partial strobe survives the clr edge.
- ir is sampled every cycle. ir changing during execute switches the decode path; the datapath guarantees IR is stable after F3.

Test Plan:
1. Reset: clr=0 at E1 of add → all outputs 0 within the same cycle, run=0. Release clr → one RST_ST cycle, then F0 with PCout=MARin=IncPC=1.
2. add R3,R1,R2 (ir=0x19890000), MEM_WAIT=1 → 7 cycles F0..E2. E1: Grc,Rout,ZLowIn, alu_op=00011. E2: ZLowout,Gra,Rin. Next cycle F0.
3. ld (ir=0x00800005), MEM_WAIT=1 → 10 cycles. Read high in FW,F2,E3,E4. MDRin only in F2 and E4. Final step MDRout,Gra,Rin.
4. br (ir=0x90000004) with con_ff=0 then con_ff=1 → 8 cycles each. PCin in E3 only when con_ff=1.
5. halt (ir=0xD0000000) → HALT after F3; run=0 and all strobes 0 for 20 cycles. Separately, stop=1 raised during E0 of add → add completes E2, then HALT, no F0.
6. Opcode 11111 → 4-cycle fetch, then F0, no execute strobes. MEM_WAIT=3 → FW lasts exactly 3 cycles, add total 9 cycles.
